// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame sequencer for the UART receive path.
// Counts oversampling edges and data bits, opens the sampler/checker
// windows, and converts checker results into one-cycle per-frame pulses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle; waiting for a falling edge while armed
// START  | start bit; strt_chk_en open, glitch rejected at bit end
// DATA   | DATA_W data bits, LSB first; deser_en strobed at each bit end
// PARITY | optional parity bit; par_chk_en open, par_err captured at bit end
// STOP   | stop bit; stp_chk_en open, result pulse issued after bit end
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  sampled_bit,
  input  logic                  par_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic [2:0]            deser_idx,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  par_err_o,
  output logic                  stp_err_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  state_t                  state;
  logic                    armed;
  logic                    par_lat;
  logic                    perr_flag;
  logic [2:0]              bit_cnt;
  logic [PRESCALE_W-1:0]   p_lat;
  logic [PRESCALE_W-1:0]   p_last;
  logic [PRESCALE_W-1:0]   p_pre;
  logic                    bit_end;
  logic                    pre_end;

  // Window outputs are registered, so they are set one cycle ahead using
  // the "next cycle is the bit end" compare (pre_end).
  assign p_last  = p_lat - PRESCALE_W'(1);
  assign p_pre   = p_lat - PRESCALE_W'(2);
  assign bit_end = (edge_cnt == p_last);
  assign pre_end = (edge_cnt == p_pre);

  // Frame sequencer: state, counters, latched frame config and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      armed       <= 1'b0;
      par_lat     <= 1'b0;
      perr_flag   <= 1'b0;
      bit_cnt     <= '0;
      p_lat       <= '0;
      edge_cnt    <= '0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      deser_idx   <= '0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      par_err_o   <= 1'b0;
      stp_err_o   <= 1'b0;
    end else begin
      deser_en    <= 1'b0;
      data_valid  <= 1'b0;
      par_err_o   <= 1'b0;
      stp_err_o   <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      dat_samp_en <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
      end

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (RX_IN) begin
            armed <= 1'b1;
          end
          // The detection cycle itself is edge 0 of the start bit.
          if (armed && !RX_IN) begin
            state       <= START;
            edge_cnt    <= PRESCALE_W'(1);
            p_lat       <= Prescale;
            par_lat     <= PAR_EN;
            perr_flag   <= 1'b0;
            strt_chk_en <= 1'b1;
            dat_samp_en <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            if (sampled_bit) begin
              state <= IDLE;
            end else begin
              state       <= DATA;
              bit_cnt     <= '0;
              dat_samp_en <= 1'b1;
            end
          end else begin
            strt_chk_en <= 1'b1;
            dat_samp_en <= 1'b1;
          end
        end

        DATA: begin
          dat_samp_en <= 1'b1;
          if (pre_end) begin
            deser_en  <= 1'b1;
            deser_idx <= bit_cnt;
          end
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state      <= par_lat ? PARITY : STOP;
              par_chk_en <= par_lat;
              stp_chk_en <= !par_lat;
            end
          end
        end

        PARITY: begin
          dat_samp_en <= 1'b1;
          if (bit_end) begin
            perr_flag  <= par_err;
            state      <= STOP;
            stp_chk_en <= 1'b1;
          end else begin
            par_chk_en <= 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            // Framing error outranks a parity error in the same frame.
            if (!sampled_bit) begin
              stp_err_o <= 1'b1;
            end else if (perr_flag) begin
              par_err_o <= 1'b1;
            end else begin
              data_valid <= 1'b1;
            end
          end else begin
            stp_chk_en  <= 1'b1;
            dat_samp_en <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
